m68k_bus_responder: RTL and testbench

M68K_BUS_RESPONDER -- requirements
Module: m68k_bus_responder

---
 rtl/m68k_bus_responder_pkg.sv | 52 +++++
 rtl/m68k_bus_responder_if.sv | 36 +++
 rtl/m68k_bus_responder.sv | 173 +++++++++++++++++
 tb/tb_m68k_bus_responder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/m68k_bus_responder_pkg.sv
// rtl/m68k_bus_responder_pkg.sv - shared constants, state encoding and select decode for the M68K bus responder
package m68k_bus_responder_pkg;

    localparam int          pcb_addr_w           = 24;
    localparam int          pcb_data_w           = 16;
    localparam int          pcb_ram_wait_default = 1;
    localparam int          pcb_ram_wait_max     = 7;
    localparam logic [15:0] pcb_unmapped_data    = 16'hFFFF;

    typedef enum logic [2:0] {
        st_idle  = 3'd0,
        st_rom   = 3'd1,
        st_ram   = 3'd2,
        st_ack   = 3'd3,
        st_drain = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        sel_none       = 4'd0,
        sel_rom        = 4'd1,
        sel_ram        = 4'd2,
        sel_shared     = 4'd3,
        sel_int_en     = 4'd4,
        sel_scroll_x   = 4'd5,
        sel_scroll_y   = 4'd6,
        sel_frame_done = 4'd7,
        sel_vblank     = 4'd8
    } sel_t;

    // Collapse the decoded selects into one winner: program ROM first, vblank status last.
    function automatic sel_t decode_sel(
        input logic rom,
        input logic ram,
        input logic shared,
        input logic int_en,
        input logic scroll_x,
        input logic scroll_y,
        input logic frame_done,
        input logic vblank
    );
        if (rom)             return sel_rom;
        else if (ram)        return sel_ram;
        else if (shared)     return sel_shared;
        else if (int_en)     return sel_int_en;
        else if (scroll_x)   return sel_scroll_x;
        else if (scroll_y)   return sel_scroll_y;
        else if (frame_done) return sel_frame_done;
        else if (vblank)     return sel_vblank;
        else                 return sel_none;
    endfunction

endpackage

// File: rtl/m68k_bus_responder_if.sv
// rtl/m68k_bus_responder_if.sv - M68K CPU bus signal bundle with CPU (master) and responder (slave) views
interface m68k_bus_responder_if;
    import m68k_bus_responder_pkg::*;

    logic [pcb_addr_w-1:0] cpu_a;
    logic                  cpu_as_n;
    logic                  cpu_rw;
    logic                  cpu_uds_n;
    logic                  cpu_lds_n;
    logic [pcb_data_w-1:0] cpu_dout;
    logic [pcb_data_w-1:0] cpu_din;
    logic                  cpu_dtack_n;

    modport master (
        output cpu_a,
        output cpu_as_n,
        output cpu_rw,
        output cpu_uds_n,
        output cpu_lds_n,
        output cpu_dout,
        input  cpu_din,
        input  cpu_dtack_n
    );

    modport slave (
        input  cpu_a,
        input  cpu_as_n,
        input  cpu_rw,
        input  cpu_uds_n,
        input  cpu_lds_n,
        input  cpu_dout,
        output cpu_din,
        output cpu_dtack_n
    );

endinterface

// File: rtl/m68k_bus_responder.sv
// rtl/m68k_bus_responder.sv - M68K bus cycle responder for program ROM, work/shared RAM and video registers
module m68k_bus_responder
    import m68k_bus_responder_pkg::*;
#(
    parameter int          RAM_WAIT      = pcb_ram_wait_default,
    parameter logic [15:0] UNMAPPED_DATA = pcb_unmapped_data
) (
    input  logic                  clk,
    input  logic                  reset_n,
    m68k_bus_responder_if.slave   bus,
    input  logic                  prog_rom_cs,
    input  logic                  ram_cs,
    input  logic                  shared_ram_cs,
    input  logic                  vblank_cs,
    input  logic                  int_en_cs,
    input  logic                  scroll_ofs_x_cs,
    input  logic                  scroll_ofs_y_cs,
    input  logic                  frame_done_cs,
    output logic                  rom_req,
    input  logic                  rom_ack,
    input  logic [pcb_data_w-1:0] rom_data,
    input  logic [pcb_data_w-1:0] ram_q,
    input  logic [pcb_data_w-1:0] shared_ram_q,
    input  logic                  vblank,
    output logic                  int_en,
    output logic [pcb_data_w-1:0] scroll_ofs_x,
    output logic [pcb_data_w-1:0] scroll_ofs_y,
    output logic                  frame_done
);

    state_t                state;
    state_t                state_nxt;
    sel_t                  sel;
    logic [2:0]            wait_cnt;
    logic                  ram_is_shared;
    logic [pcb_data_w-1:0] din_q;
    logic                  dtack_n;
    logic                  as_active;
    logic                  wait_done;

    assign as_active = ~bus.cpu_as_n;
    assign wait_done = (wait_cnt <= 3'd1);
    assign sel = decode_sel(prog_rom_cs, ram_cs, shared_ram_cs, int_en_cs,
                            scroll_ofs_x_cs, scroll_ofs_y_cs, frame_done_cs, vblank_cs);

    assign bus.cpu_din     = din_q;
    assign bus.cpu_dtack_n = dtack_n;

    // State register; reset drops the FSM straight back to idle so DTACK and rom_req clear without a clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= st_idle;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: ROM/RAM waits, abort handling when AS rises early, and the AS-release handshake in ACK.
    always_comb begin
        state_nxt = state;
        case (state)
            st_idle: begin
                if (as_active) begin
                    case (sel)
                        sel_rom:             state_nxt = st_rom;
                        sel_ram, sel_shared: state_nxt = st_ram;
                        default:             state_nxt = st_ack;
                    endcase
                end
            end
            st_rom: begin
                if (!as_active) begin
                    state_nxt = rom_ack ? st_idle : st_drain;
                end else if (rom_ack) begin
                    state_nxt = st_ack;
                end
            end
            st_ram: begin
                if (!as_active) begin
                    state_nxt = st_idle;
                end else if (wait_done) begin
                    state_nxt = st_ack;
                end
            end
            st_ack: begin
                if (!as_active) begin
                    state_nxt = st_idle;
                end
            end
            st_drain: begin
                if (rom_ack) begin
                    state_nxt = st_idle;
                end
            end
            default: state_nxt = st_idle;
        endcase
    end

    // Outputs decoded from state: DTACK releases combinationally the moment AS rises.
    always_comb begin
        dtack_n = 1'b1;
        rom_req = 1'b0;
        if (state == st_ack && as_active) begin
            dtack_n = 1'b0;
        end
        if (state == st_rom || state == st_drain) begin
            rom_req = 1'b1;
        end
    end

    // Datapath: register writes and immediate reads on the idle exit, ROM/RAM data capture, wait counting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            din_q         <= '0;
            wait_cnt      <= '0;
            ram_is_shared <= 1'b0;
            int_en        <= 1'b0;
            scroll_ofs_x  <= '0;
            scroll_ofs_y  <= '0;
            frame_done    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                st_idle: begin
                    if (as_active) begin
                        if (sel == sel_ram || sel == sel_shared) begin
                            wait_cnt      <= 3'(RAM_WAIT);
                            ram_is_shared <= (sel == sel_shared);
                        end
                        if (bus.cpu_rw) begin
                            if (sel == sel_vblank) begin
                                din_q <= {15'h0, vblank};
                            end else if (sel != sel_rom && sel != sel_ram && sel != sel_shared) begin
                                din_q <= UNMAPPED_DATA;
                            end
                        end else begin
                            case (sel)
                                sel_int_en: int_en <= bus.cpu_dout[0];
                                sel_scroll_x: begin
                                    if (!bus.cpu_uds_n) scroll_ofs_x[15:8] <= bus.cpu_dout[15:8];
                                    if (!bus.cpu_lds_n) scroll_ofs_x[7:0]  <= bus.cpu_dout[7:0];
                                end
                                sel_scroll_y: begin
                                    if (!bus.cpu_uds_n) scroll_ofs_y[15:8] <= bus.cpu_dout[15:8];
                                    if (!bus.cpu_lds_n) scroll_ofs_y[7:0]  <= bus.cpu_dout[7:0];
                                end
                                sel_frame_done: frame_done <= 1'b1;
                                default: ;
                            endcase
                        end
                    end
                end
                st_rom: begin
                    if (as_active && rom_ack) begin
                        din_q <= rom_data;
                    end
                end
                st_ram: begin
                    if (!as_active) begin
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_done ? 3'd0 : wait_cnt - 3'd1;
                        if (wait_done) begin
                            din_q <= ram_is_shared ? shared_ram_q : ram_q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_m68k_bus_responder.sv
// tb/tb_m68k_bus_responder.sv - directed self-checking bench for m68k_bus_responder
module tb_m68k_bus_responder;

    logic        clk;
    logic        reset_n;
    logic        prog_rom_cs, ram_cs, shared_ram_cs, vblank_cs;
    logic        int_en_cs, scroll_ofs_x_cs, scroll_ofs_y_cs, frame_done_cs;
    logic        rom_req, rom_ack;
    logic [15:0] rom_data, ram_q, shared_ram_q;
    logic        vblank;
    logic        int_en;
    logic [15:0] scroll_ofs_x, scroll_ofs_y;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    m68k_bus_responder_if bus();

    m68k_bus_responder #(.RAM_WAIT(2), .UNMAPPED_DATA(16'hFFFF)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .bus             (bus.slave),
        .prog_rom_cs     (prog_rom_cs),
        .ram_cs          (ram_cs),
        .shared_ram_cs   (shared_ram_cs),
        .vblank_cs       (vblank_cs),
        .int_en_cs       (int_en_cs),
        .scroll_ofs_x_cs (scroll_ofs_x_cs),
        .scroll_ofs_y_cs (scroll_ofs_y_cs),
        .frame_done_cs   (frame_done_cs),
        .rom_req         (rom_req),
        .rom_ack         (rom_ack),
        .rom_data        (rom_data),
        .ram_q           (ram_q),
        .shared_ram_q    (shared_ram_q),
        .vblank          (vblank),
        .int_en          (int_en),
        .scroll_ofs_x    (scroll_ofs_x),
        .scroll_ofs_y    (scroll_ofs_y),
        .frame_done      (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_bus();
        bus.cpu_as_n    = 1'b1;
        bus.cpu_rw      = 1'b1;
        bus.cpu_uds_n   = 1'b1;
        bus.cpu_lds_n   = 1'b1;
        prog_rom_cs     = 1'b0;
        ram_cs          = 1'b0;
        shared_ram_cs   = 1'b0;
        vblank_cs       = 1'b0;
        int_en_cs       = 1'b0;
        scroll_ofs_x_cs = 1'b0;
        scroll_ofs_y_cs = 1'b0;
        frame_done_cs   = 1'b0;
    endtask

    task automatic start_cycle(input logic rw, input logic uds_n, input logic lds_n,
                               input logic [15:0] dout, input logic [23:0] addr);
        bus.cpu_a     = addr;
        bus.cpu_rw    = rw;
        bus.cpu_uds_n = uds_n;
        bus.cpu_lds_n = lds_n;
        bus.cpu_dout  = dout;
        bus.cpu_as_n  = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_bus();
        bus.cpu_a = '0; bus.cpu_dout = '0;
        rom_ack = 1'b0; rom_data = '0; ram_q = '0; shared_ram_q = '0; vblank = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.cpu_dtack_n !== 1'b1) begin n_fail++; $display("FAIL reset_dtack: got %b expected 1", bus.cpu_dtack_n); end
        n_checks++; if (rom_req !== 1'b0) begin n_fail++; $display("FAIL reset_rom_req: got %b expected 0", rom_req); end
        n_checks++; if (bus.cpu_din !== 16'h0000) begin n_fail++; $display("FAIL reset_din: got %h expected 0000", bus.cpu_din); end
        n_checks++; if ({int_en, frame_done, scroll_ofs_x, scroll_ofs_y} !== 34'h0) begin n_fail++; $display("FAIL reset_regs: got %b %b %h %h expected all zero", int_en, frame_done, scroll_ofs_x, scroll_ofs_y); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_rom_read();
        @(negedge clk);
        start_cycle(1'b1, 1'b0, 1'b0, 16'h0000, 24'h000400);
        prog_rom_cs = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            n_checks++; if (rom_req !== 1'b1 || bus.cpu_dtack_n !== 1'b1) begin n_fail++; $display("FAIL rom_wait[%0d]: got req=%b dtack_n=%b expected req=1 dtack_n=1", i, rom_req, bus.cpu_dtack_n); end
            if (i == 5) begin rom_ack = 1'b1; rom_data = 16'h4E71; end
        end
        @(negedge clk);
        rom_ack = 1'b0; rom_data = 16'h0000;
        n_checks++; if (bus.cpu_dtack_n !== 1'b0) begin n_fail++; $display("FAIL rom_dtack: got %b expected 0", bus.cpu_dtack_n); end
        n_checks++; if (bus.cpu_din !== 16'h4E71) begin n_fail++; $display("FAIL rom_data: got %h expected 4e71", bus.cpu_din); end
        n_checks++; if (rom_req !== 1'b0) begin n_fail++; $display("FAIL rom_req_drop: got %b expected 0", rom_req); end
        @(negedge clk);
        n_checks++; if (bus.cpu_dtack_n !== 1'b0) begin n_fail++; $display("FAIL rom_dtack_hold: got %b expected 0", bus.cpu_dtack_n); end
        idle_bus();
        #1;
        n_checks++; if (bus.cpu_dtack_n !== 1'b1) begin n_fail++; $display("FAIL rom_dtack_release: got %b expected 1", bus.cpu_dtack_n); end
        @(negedge clk);
        n_checks++; if (bus.cpu_din !== 16'h4E71) begin n_fail++; $display("FAIL rom_din_hold: got %h expected 4e71", bus.cpu_din); end
    endtask

    task automatic test_ram_read();
        ram_q = 16'h1234; shared_ram_q = 16'h5678;
        @(negedge clk);
        start_cycle(1'b1, 1'b0, 1'b0, 16'h0000, 24'hFF0000);
        ram_cs = 1'b1; shared_ram_cs = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk);
            n_checks++; if (bus.cpu_dtack_n !== 1'b1) begin n_fail++; $display("FAIL ram_wait[%0d]: got %b expected 1", i, bus.cpu_dtack_n); end
        end
        @(negedge clk);
        n_checks++; if (bus.cpu_dtack_n !== 1'b0) begin n_fail++; $display("FAIL ram_dtack: got %b expected 0", bus.cpu_dtack_n); end
        n_checks++; if (bus.cpu_din !== 16'h1234) begin n_fail++; $display("FAIL ram_data_priority: got %h expected 1234", bus.cpu_din); end
        idle_bus();
        @(negedge clk);
        start_cycle(1'b1, 1'b0, 1'b0, 16'h0000, 24'h100000);
        shared_ram_cs = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.cpu_dtack_n !== 1'b0 || bus.cpu_din !== 16'h5678) begin n_fail++; $display("FAIL shared_data: got dtack_n=%b din=%h expected 0 5678", bus.cpu_dtack_n, bus.cpu_din); end
        idle_bus();
        @(negedge clk);
    endtask

    task automatic test_register_writes();
        start_cycle(1'b0, 1'b1, 1'b0, 16'hABCD, 24'h200000);
        scroll_ofs_x_cs = 1'b1;
        @(negedge clk);
        n_checks++; if (scroll_ofs_x !== 16'h00CD) begin n_fail++; $display("FAIL scroll_x_lds: got %h expected 00cd", scroll_ofs_x); end
        n_checks++; if (bus.cpu_dtack_n !== 1'b0) begin n_fail++; $display("FAIL reg_dtack_latency: got %b expected 0", bus.cpu_dtack_n); end
        n_checks++; if (bus.cpu_din !== 16'h5678) begin n_fail++; $display("FAIL din_hold_on_write: got %h expected 5678", bus.cpu_din); end
        idle_bus();
        @(negedge clk);
        start_cycle(1'b0, 1'b0, 1'b1, 16'h1234, 24'h200000);
        scroll_ofs_x_cs = 1'b1;
        @(negedge clk);
        n_checks++; if (scroll_ofs_x !== 16'h12CD) begin n_fail++; $display("FAIL scroll_x_uds: got %h expected 12cd", scroll_ofs_x); end
        idle_bus();
        @(negedge clk);
        start_cycle(1'b0, 1'b0, 1'b0, 16'hBEEF, 24'h200002);
        scroll_ofs_y_cs = 1'b1;
        @(negedge clk);
        n_checks++; if (scroll_ofs_y !== 16'hBEEF || scroll_ofs_x !== 16'h12CD) begin n_fail++; $display("FAIL scroll_y_word: got y=%h x=%h expected beef 12cd", scroll_ofs_y, scroll_ofs_x); end
        idle_bus();
        @(negedge clk);
        start_cycle(1'b0, 1'b1, 1'b1, 16'hFFFF, 24'h200006);
        frame_done_cs = 1'b1;
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL frame_done_pre: got %b expected 0", frame_done); end
        @(negedge clk);
        n_checks++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL frame_done_pulse: got %b expected 1", frame_done); end
        @(negedge clk);
        n_checks++; if (frame_done !== 1'b0 || bus.cpu_dtack_n !== 1'b0) begin n_fail++; $display("FAIL frame_done_width: got fd=%b dtack_n=%b expected 0 0", frame_done, bus.cpu_dtack_n); end
        n_checks++; if (int_en !== 1'b0 || scroll_ofs_y !== 16'hBEEF) begin n_fail++; $display("FAIL frame_done_side: got int_en=%b y=%h expected 0 beef", int_en, scroll_ofs_y); end
        idle_bus();
        @(negedge clk);
        start_cycle(1'b0, 1'b1, 1'b0, 16'h0001, 24'h200004);
        int_en_cs = 1'b1;
        @(negedge clk);
        n_checks++; if (int_en !== 1'b1) begin n_fail++; $display("FAIL int_en_write: got %b expected 1", int_en); end
        idle_bus();
        @(negedge clk);
    endtask

    task automatic test_rom_abort();
        rom_data = 16'hDEAD;
        start_cycle(1'b1, 1'b0, 1'b0, 16'h0000, 24'h000800);
        prog_rom_cs = 1'b1;
        @(negedge clk);
        n_checks++; if (rom_req !== 1'b1) begin n_fail++; $display("FAIL abort_req_start: got %b expected 1", rom_req); end
        @(negedge clk);
        idle_bus();
        for (int i = 3; i <= 6; i++) begin
            @(negedge clk);
            n_checks++; if (rom_req !== 1'b1 || bus.cpu_dtack_n !== 1'b1) begin n_fail++; $display("FAIL drain[%0d]: got req=%b dtack_n=%b expected 1 1", i, rom_req, bus.cpu_dtack_n); end
            if (i == 6) rom_ack = 1'b1;
        end
        @(negedge clk);
        rom_ack = 1'b0;
        n_checks++; if (rom_req !== 1'b0 || bus.cpu_dtack_n !== 1'b1) begin n_fail++; $display("FAIL drain_done: got req=%b dtack_n=%b expected 0 1", rom_req, bus.cpu_dtack_n); end
        n_checks++; if (bus.cpu_din !== 16'h5678) begin n_fail++; $display("FAIL drain_discard: got %h expected 5678", bus.cpu_din); end
        start_cycle(1'b1, 1'b0, 1'b0, 16'h0000, 24'h000802);
        prog_rom_cs = 1'b1;
        @(negedge clk);
        rom_ack = 1'b1; rom_data = 16'h1111;
        @(negedge clk);
        rom_ack = 1'b0; rom_data = 16'h0000;
        n_checks++; if (bus.cpu_dtack_n !== 1'b0 || bus.cpu_din !== 16'h1111) begin n_fail++; $display("FAIL rom_after_abort: got dtack_n=%b din=%h expected 0 1111", bus.cpu_dtack_n, bus.cpu_din); end
        idle_bus();
        @(negedge clk);
    endtask

    task automatic test_unmapped_and_status();
        start_cycle(1'b1, 1'b0, 1'b0, 16'h0000, 24'h700000);
        @(negedge clk);
        n_checks++; if (bus.cpu_dtack_n !== 1'b0 || bus.cpu_din !== 16'hFFFF) begin n_fail++; $display("FAIL unmapped_read: got dtack_n=%b din=%h expected 0 ffff", bus.cpu_dtack_n, bus.cpu_din); end
        @(negedge clk);
        n_checks++; if (bus.cpu_dtack_n !== 1'b0) begin n_fail++; $display("FAIL ack_held_while_as: got %b expected 0", bus.cpu_dtack_n); end
        idle_bus();
        vblank = 1'b1;
        @(negedge clk);
        start_cycle(1'b1, 1'b0, 1'b0, 16'h0000, 24'h300000);
        vblank_cs = 1'b1;
        @(negedge clk);
        vblank = 1'b0;
        n_checks++; if (bus.cpu_din !== 16'h0001 || bus.cpu_dtack_n !== 1'b0) begin n_fail++; $display("FAIL vblank_read: got din=%h dtack_n=%b expected 0001 0", bus.cpu_din, bus.cpu_dtack_n); end
        idle_bus();
        @(negedge clk);
        start_cycle(1'b1, 1'b0, 1'b0, 16'h0000, 24'h200002);
        scroll_ofs_y_cs = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.cpu_din !== 16'hFFFF || scroll_ofs_y !== 16'hBEEF) begin n_fail++; $display("FAIL write_only_read: got din=%h y=%h expected ffff beef", bus.cpu_din, scroll_ofs_y); end
        idle_bus();
        vblank = 1'b1;
        @(negedge clk);
        start_cycle(1'b1, 1'b0, 1'b0, 16'h0000, 24'h300000);
        vblank_cs = 1'b1; int_en_cs = 1'b1;
        @(negedge clk);
        vblank = 1'b0;
        n_checks++; if (bus.cpu_din !== 16'hFFFF) begin n_fail++; $display("FAIL reg_over_vblank: got %h expected ffff", bus.cpu_din); end
        idle_bus();
        @(negedge clk);
    endtask

    task automatic test_reset_in_rom();
        start_cycle(1'b1, 1'b0, 1'b0, 16'h0000, 24'h000400);
        prog_rom_cs = 1'b1;
        @(negedge clk);
        n_checks++; if (rom_req !== 1'b1) begin n_fail++; $display("FAIL rst_rom_pre: got %b expected 1", rom_req); end
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (rom_req !== 1'b0 || bus.cpu_dtack_n !== 1'b1) begin n_fail++; $display("FAIL rst_rom_async: got req=%b dtack_n=%b expected 0 1", rom_req, bus.cpu_dtack_n); end
        @(negedge clk);
        idle_bus();
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_in_ack();
        start_cycle(1'b0, 1'b1, 1'b0, 16'h0001, 24'h200004);
        int_en_cs = 1'b1;
        @(negedge clk);
        idle_bus();
        @(negedge clk);
        start_cycle(1'b1, 1'b0, 1'b0, 16'h0000, 24'h700000);
        @(negedge clk);
        n_checks++; if (bus.cpu_dtack_n !== 1'b0 || int_en !== 1'b1) begin n_fail++; $display("FAIL rst_ack_pre: got dtack_n=%b int_en=%b expected 0 1", bus.cpu_dtack_n, int_en); end
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (bus.cpu_dtack_n !== 1'b1 || int_en !== 1'b0 || rom_req !== 1'b0) begin n_fail++; $display("FAIL rst_ack_async: got dtack_n=%b int_en=%b req=%b expected 1 0 0", bus.cpu_dtack_n, int_en, rom_req); end
        n_checks++; if (bus.cpu_din !== 16'h0000 || scroll_ofs_x !== 16'h0000 || scroll_ofs_y !== 16'h0000) begin n_fail++; $display("FAIL rst_ack_regs: got din=%h x=%h y=%h expected 0000", bus.cpu_din, scroll_ofs_x, scroll_ofs_y); end
        @(negedge clk);
        idle_bus();
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_rom_read();
        test_ram_read();
        test_register_writes();
        test_rom_abort();
        test_unmapped_and_status();
        test_reset_in_rom();
        test_reset_in_ack();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
